// File: rtl/line_prefetch_sink.sv
// Final display pipeline stage: prefetches each line in credit-limited chunks, buffers
// returned pixels locally and emits 8-8-8 RGB aligned with the timing delayed by one clock.
module line_prefetch_sink #(
    parameter int CHUNK_BITS      = 5,
    parameter int HACTIVE_BITS    = 11,
    parameter int VACTIVE_BITS    = 11,
    parameter int FIFO_ADDR_BITS  = 7,
    parameter int LATE_COUNT_BITS = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [HACTIVE_BITS-1:0]          hActive,
    input  logic [VACTIVE_BITS-1:0]          vActive,
    input  logic                             pixelFormat,
    input  logic [23:0]                      fillColor,
    input  logic                             inDataEnable,
    input  logic                             inHSync,
    input  logic                             inVSync,
    input  logic                             inActiveVideoPreamble,
    input  logic                             inActiveVideoGuardBand,
    output logic                             requestValid,
    input  logic                             requestReady,
    output logic [VACTIVE_BITS-1:0]          requestLine,
    output logic [HACTIVE_BITS-CHUNK_BITS-1:0] requestChunk,
    input  logic                             pixelValid,
    output logic                             pixelReady,
    input  logic [23:0]                      pixelData,
    output logic                             dataEnable,
    output logic                             hSync,
    output logic                             vSync,
    output logic                             activeVideoPreamble,
    output logic                             activeVideoGuardBand,
    output logic [7:0]                       red,
    output logic [7:0]                       green,
    output logic [7:0]                       blue,
    output logic                             late,
    output logic [LATE_COUNT_BITS-1:0]       lateCount
);

    localparam int CW    = HACTIVE_BITS - CHUNK_BITS;
    localparam int CHUNK = 1 << CHUNK_BITS;
    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int CNT_W = FIFO_ADDR_BITS + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FETCH, DONE} state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      vsync_prev;
    logic                      vsync_rise;
    logic                      fmt_888;
    logic [VACTIVE_BITS-1:0]   line_idx;
    logic [CW-1:0]             chunk_idx;
    logic [CW-1:0]             last_chunk;
    logic [CHUNK_BITS-1:0]     tail;
    logic                      last_line;
    logic                      empty_frame;
    logic [CNT_W-1:0]          chunk_size;
    logic [CNT_W-1:0]          outstanding;
    logic [CNT_W-1:0]          outstanding_next;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W-1:0]          free_credit;
    logic [FIFO_ADDR_BITS-1:0] wr_ptr;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr;
    logic [23:0]               fifo_mem [DEPTH];
    logic [23:0]               pix_rgb;
    logic                      req_acc;
    logic                      pix_acc;
    logic                      push;
    logic                      pop;
    logic                      last_req;

    function automatic logic [23:0] expand_565(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    function automatic logic [LATE_COUNT_BITS-1:0] sat_inc(input logic [LATE_COUNT_BITS-1:0] v);
        return (&v) ? v : v + LATE_COUNT_BITS'(1);
    endfunction

    assign vsync_rise  = inVSync & ~vsync_prev;
    assign empty_frame = (hActive == '0) || (vActive == '0);
    assign last_chunk  = CW'((hActive - HACTIVE_BITS'(1)) >> CHUNK_BITS);
    assign tail        = hActive[CHUNK_BITS-1:0];
    assign last_line   = (line_idx == vActive - VACTIVE_BITS'(1));

    // Only the final chunk of a line may be short; a zero remainder means it is full.
    assign chunk_size  = (chunk_idx == last_chunk && tail != '0) ? CNT_W'(tail) : CNT_W'(CHUNK);
    assign free_credit = CNT_W'(DEPTH) - fifo_count - outstanding;

    // Credit only shrinks on an accepted request, so once raised the request stays up.
    assign requestValid = (state == FETCH) && !empty_frame && !vsync_rise &&
                          (free_credit >= chunk_size);
    assign requestLine  = line_idx;
    assign requestChunk = chunk_idx;
    assign pixelReady   = (outstanding != '0);

    assign req_acc  = requestValid && requestReady;
    assign pix_acc  = pixelValid && pixelReady;
    assign push     = pix_acc && (state == FETCH || state == DONE) && !vsync_rise;
    assign pop      = inDataEnable && (fifo_count != '0);
    assign last_req = req_acc && (chunk_idx == last_chunk) && last_line;
    assign pix_rgb  = fmt_888 ? pixelData : expand_565(pixelData[15:0]);

    assign outstanding_next = outstanding + (req_acc ? chunk_size : '0) - CNT_W'(pix_acc);

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (vsync_rise) begin
            state_next = DRAIN;
        end else begin
            case (state)
                IDLE:  state_next = IDLE;
                DRAIN: if (outstanding == '0) state_next = FETCH;
                FETCH: if (empty_frame || last_req) state_next = DONE;
                DONE:  state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Request bookkeeping and FIFO pointers; a vSync rise restarts the frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vsync_prev  <= 1'b0;
            fmt_888     <= 1'b0;
            line_idx    <= '0;
            chunk_idx   <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            assert (!(push && !pop && fifo_count == CNT_W'(DEPTH)));
            vsync_prev  <= inVSync;
            outstanding <= outstanding_next;
            if (vsync_rise) begin
                fmt_888    <= pixelFormat;
                line_idx   <= '0;
                chunk_idx  <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (req_acc) begin
                    if (chunk_idx == last_chunk) begin
                        chunk_idx <= '0;
                        line_idx  <= line_idx + VACTIVE_BITS'(1);
                    end else begin
                        chunk_idx <= chunk_idx + CW'(1);
                    end
                end
                if (push) wr_ptr <= wr_ptr + FIFO_ADDR_BITS'(1);
                if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_BITS'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= pix_rgb;
    end

    // Output stage: timing delayed one clock, colour from FIFO or fill on underrun.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dataEnable           <= 1'b0;
            hSync                <= 1'b0;
            vSync                <= 1'b0;
            activeVideoPreamble  <= 1'b0;
            activeVideoGuardBand <= 1'b0;
            red                  <= '0;
            green                <= '0;
            blue                 <= '0;
            late                 <= 1'b0;
            lateCount            <= '0;
        end else begin
            dataEnable           <= inDataEnable;
            hSync                <= inHSync;
            vSync                <= inVSync;
            activeVideoPreamble  <= inActiveVideoPreamble;
            activeVideoGuardBand <= inActiveVideoGuardBand;
            late                 <= 1'b0;
            if (inDataEnable) begin
                if (pop) begin
                    {red, green, blue} <= fifo_mem[rd_ptr];
                end else begin
                    {red, green, blue} <= fillColor;
                    late               <= 1'b1;
                    lateCount          <= sat_inc(lateCount);
                end
            end else begin
                {red, green, blue} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_line_prefetch_sink.sv
// Directed bench for line_prefetch_sink (64-deep FIFO, 32-pixel chunks) with an ideal upstream model.
module tb_line_prefetch_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] hActive;
    logic [10:0] vActive;
    logic        pixelFormat;
    logic [23:0] fillColor;
    logic        inDataEnable, inHSync, inVSync, inActiveVideoPreamble, inActiveVideoGuardBand;
    logic        requestValid, requestReady;
    logic [10:0] requestLine;
    logic [5:0]  requestChunk;
    logic        pixelValid, pixelReady;
    logic [23:0] pixelData;
    logic        dataEnable, hSync, vSync, activeVideoPreamble, activeVideoGuardBand;
    logic [7:0]  red, green, blue;
    logic        late;
    logic [7:0]  lateCount;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          resp_pending = 0;
    int          pix_accepted = 0;
    int          req_total = 0;
    int          base_req, base_pix;
    bit          resp_on = 1'b0;
    logic [23:0] pix_word;
    int          req_log[$];

    line_prefetch_sink #(
        .CHUNK_BITS(5), .HACTIVE_BITS(11), .VACTIVE_BITS(11),
        .FIFO_ADDR_BITS(6), .LATE_COUNT_BITS(8)
    ) dut (
        .clock(clock), .reset(reset), .hActive(hActive), .vActive(vActive),
        .pixelFormat(pixelFormat), .fillColor(fillColor),
        .inDataEnable(inDataEnable), .inHSync(inHSync), .inVSync(inVSync),
        .inActiveVideoPreamble(inActiveVideoPreamble),
        .inActiveVideoGuardBand(inActiveVideoGuardBand),
        .requestValid(requestValid), .requestReady(requestReady),
        .requestLine(requestLine), .requestChunk(requestChunk),
        .pixelValid(pixelValid), .pixelReady(pixelReady), .pixelData(pixelData),
        .dataEnable(dataEnable), .hSync(hSync), .vSync(vSync),
        .activeVideoPreamble(activeVideoPreamble),
        .activeVideoGuardBand(activeVideoGuardBand),
        .red(red), .green(green), .blue(blue), .late(late), .lateCount(lateCount)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int chunk_len(input int c);
        int h;
        h = int'(hActive);
        if (c == (h - 1) / 32 && h % 32 != 0) return h % 32;
        return 32;
    endfunction

    // Upstream model: answers every accepted request with its pixels, one per clock.
    task automatic cyc();
        pixelValid = resp_on && (resp_pending > 0);
        pixelData  = pix_word;
        #1;
        if (requestValid && requestReady) begin
            req_total++;
            req_log.push_back(int'(requestLine) * 64 + int'(requestChunk));
            resp_pending += chunk_len(int'(requestChunk));
        end
        if (pixelValid && pixelReady) begin
            pix_accepted++;
            resp_pending--;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic vsync_pulse();
        inVSync = 1'b1;
        cyc();
        inVSync = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; hActive = 11'd64; vActive = 11'd2; pixelFormat = 1'b1;
        fillColor = 24'hA5C3E7; pix_word = 24'h123456;
        inDataEnable = 1'b1; inHSync = 1'b1; inVSync = 1'b0;
        inActiveVideoPreamble = 1'b0; inActiveVideoGuardBand = 1'b0;
        requestReady = 1'b1; pixelValid = 1'b0; pixelData = '0;

        // reset holds every output low even with timing inputs active
        run(3);
        check_val("rst_reqvalid", requestValid, 0);
        check_val("rst_pixready", pixelReady, 0);
        check_val("rst_de", dataEnable, 0);
        check_val("rst_hsync", hSync, 0);
        check_val("rst_vsync", vSync, 0);
        check_val("rst_rgb", {red, green, blue}, 0);
        check_val("rst_late", late, 0);
        check_val("rst_latecnt", lateCount, 0);
        inDataEnable = 1'b0; inHSync = 1'b0; reset = 1'b1;
        run(2);

        // 64x2 frame, ideal upstream, RGB888
        resp_on = 1'b1;
        vsync_pulse();
        run(80);
        check_val("a_req_line0", req_total, 2);
        check_val("a_pix_line0", pix_accepted, 64);
        inDataEnable = 1'b1; inHSync = 1'b1; inActiveVideoGuardBand = 1'b1;
        cyc();
        inHSync = 1'b0; inActiveVideoGuardBand = 1'b0;
        check_val("a_de", dataEnable, 1);
        check_val("a_hsync", hSync, 1);
        check_val("a_guard", activeVideoGuardBand, 1);
        check_val("a_rgb888", {red, green, blue}, 24'h123456);
        check_val("a_late", late, 0);
        run(127);
        inDataEnable = 1'b0;
        cyc();
        check_val("a_de_off", dataEnable, 0);
        check_val("a_rgb_blank", {red, green, blue}, 0);
        check_val("a_latecnt", lateCount, 0);
        run(50);
        check_val("a_req_total", req_total, 4);
        check_val("a_req0", req_log[0], 0);
        check_val("a_req1", req_log[1], 1);
        check_val("a_req2", req_log[2], 64);
        check_val("a_req3", req_log[3], 65);
        check_val("a_done_rv", requestValid, 0);

        // credit limit: no pixels returned, 64-pixel lines
        resp_on = 1'b0; hActive = 11'd64; vActive = 11'd4; pixelFormat = 1'b0;
        base_req = req_total;
        vsync_pulse();
        run(10);
        check_val("c_req_count", req_total - base_req, 2);
        check_val("c_rv_blocked", requestValid, 0);
        check_val("c_req_last", req_log[req_log.size() - 1], 1);

        // drain those 64 pixels under a new 40-pixel frame
        requestReady = 1'b0; resp_on = 1'b1; hActive = 11'd40;
        vsync_pulse();
        for (int i = 0; i < 100 && resp_pending > 0; i++) cyc();
        check_val("b_drain_done", resp_pending, 0);
        resp_on = 1'b0; requestReady = 1'b1;
        base_req = req_total;
        run(6);
        check_val("b_req_count", req_total - base_req, 2);
        check_val("b_req_first", req_log[req_log.size() - 2], 0);
        check_val("b_req_second", req_log[req_log.size() - 1], 1);
        check_val("b_rv_blocked", requestValid, 0);
        requestReady = 1'b0; resp_on = 1'b1; pix_word = 24'hABF800;
        base_pix = pix_accepted;
        run(60);
        check_val("b_outstanding40", pix_accepted - base_pix, 40);
        check_val("b_pixready_off", pixelReady, 0);
        check_val("b_rv_after_fill", requestValid, 0);
        resp_on = 1'b0;
        inDataEnable = 1'b1;
        cyc();
        check_val("b_rgb565_red", {red, green, blue}, 24'hFF0000);
        check_val("b_late", late, 0);
        run(6);
        inDataEnable = 1'b0;
        check_val("b_rv_free31", requestValid, 0);
        inDataEnable = 1'b1;
        cyc();
        inDataEnable = 1'b0;
        check_val("b_rv_free32", requestValid, 1);
        check_val("b_req_line", requestLine, 1);
        check_val("b_req_chunk", requestChunk, 0);

        // underrun: flushed FIFO, no requests accepted
        vsync_pulse();
        run(3);
        inDataEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("d_late_pulse", late, 1);
            check_val("d_fill_rgb", {red, green, blue}, 24'hA5C3E7);
        end
        inDataEnable = 1'b0;
        cyc();
        check_val("d_late_off", late, 0);
        check_val("d_latecnt3", lateCount, 3);
        check_val("d_rgb_blank", {red, green, blue}, 0);
        inDataEnable = 1'b1;
        run(300);
        inDataEnable = 1'b0;
        cyc();
        check_val("d_latecnt_sat", lateCount, 255);

        // vSync rise with 20 pixels outstanding
        hActive = 11'd20; vActive = 11'd1; requestReady = 1'b1;
        base_req = req_total;
        vsync_pulse();
        run(6);
        check_val("e_req_one", req_total - base_req, 1);
        check_val("e_done_rv", requestValid, 0);
        check_val("e_pending20", resp_pending, 20);
        vsync_pulse();
        run(5);
        check_val("e_drain_noreq", req_total - base_req, 1);
        check_val("e_drain_pixready", pixelReady, 1);
        requestReady = 1'b0; resp_on = 1'b1;
        base_pix = pix_accepted;
        for (int i = 0; i < 60 && resp_pending > 0; i++) cyc();
        resp_on = 1'b0;
        check_val("e_discarded20", pix_accepted - base_pix, 20);
        run(2);
        check_val("e_rv_restart", requestValid, 1);
        check_val("e_req_line0", requestLine, 0);
        check_val("e_req_chunk0", requestChunk, 0);
        inDataEnable = 1'b1;
        cyc();
        inDataEnable = 1'b0;
        check_val("e_fifo_empty_late", late, 1);

        // reset in the middle of a line with pixels in flight
        requestReady = 1'b1;
        cyc();
        requestReady = 1'b0;
        check_val("f_inflight", resp_pending, 20);
        reset = 1'b0; inDataEnable = 1'b1; inHSync = 1'b1; inActiveVideoPreamble = 1'b1;
        cyc();
        check_val("f_rst_de", dataEnable, 0);
        check_val("f_rst_hsync", hSync, 0);
        check_val("f_rst_preamble", activeVideoPreamble, 0);
        check_val("f_rst_rgb", {red, green, blue}, 0);
        check_val("f_rst_late", late, 0);
        check_val("f_rst_latecnt", lateCount, 0);
        check_val("f_rst_rv", requestValid, 0);
        check_val("f_rst_pixready", pixelReady, 0);
        reset = 1'b1; inDataEnable = 1'b0; inHSync = 1'b0; inActiveVideoPreamble = 1'b0;
        resp_on = 1'b1;
        base_pix = pix_accepted;
        run(5);
        check_val("f_refused", pix_accepted - base_pix, 0);
        check_val("f_pixready_off", pixelReady, 0);
        resp_on = 1'b0; resp_pending = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
